// File: rtl/mem_port_arbiter_rv_pkg.sv
// Shared encodings and helpers for the fetch/data memory-port arbiter.
package mem_port_arbiter_rv_pkg;

  localparam logic [1:0] ARB_STATE_IDLE  = 2'd0;
  localparam logic [1:0] ARB_STATE_ISSUE = 2'd1;
  localparam logic [1:0] ARB_STATE_WAIT  = 2'd2;
  localparam logic [1:0] ARB_STATE_RESP  = 2'd3;

  localparam logic ARB_GRANT_FETCH = 1'b0;
  localparam logic ARB_GRANT_DATA  = 1'b1;

  localparam int STREAK_W = 4;
  localparam int WAIT_W   = 3;

  typedef struct packed {
    logic        grantId;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } arbReq_t;

  function automatic logic [31:0] wordAlign(input logic [31:0] byteAddr);
    return byteAddr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/arb_pick_rv.sv
// Grant selection with fixed data-over-fetch priority and a saturating
// data-streak counter that forces a fetch grant once the limit is reached.
module arb_pick_rv
  import mem_port_arbiter_rv_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic iwClk,
  input  logic iwRst,
  input  logic iwFetchReq,
  input  logic iwDataReq,
  input  logic iwGrantValid,
  output logic owGrantId
);

  logic [STREAK_W-1:0] streakReg;
  logic [STREAK_W-1:0] streakNext;
  logic                streakFull;
  logic                dataWins;

  always_comb begin
    streakFull = (streakReg == STREAK_W'(MAX_DATA_STREAK));
    dataWins   = iwDataReq && !(streakFull && iwFetchReq);
    owGrantId  = dataWins ? ARB_GRANT_DATA : ARB_GRANT_FETCH;
    streakNext = streakReg;
    // Only a data grant that overtakes a waiting fetch extends the streak.
    if (iwGrantValid) begin
      if (dataWins && iwFetchReq) begin
        streakNext = streakFull ? streakReg : streakReg + 1'b1;
      end else begin
        streakNext = '0;
      end
    end
  end

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      streakReg <= '0;
    end else begin
      streakReg <= streakNext;
    end
  end

endmodule

// File: rtl/mem_port_arbiter_rv.sv
// Serialises instruction-fetch and data accesses onto one synchronous RAM port
// (IDLE -> ISSUE -> WAIT -> RESP) and returns a one-cycle done per requester.
module mem_port_arbiter_rv
  import mem_port_arbiter_rv_pkg::*;
#(
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic        iwFetchReq,
  input  logic [31:0] iwFetchAddr,
  output logic        owFetchDone,
  output logic [31:0] owFetchData,
  input  logic        iwDataReq,
  input  logic [31:0] iwDataAddr,
  input  logic [31:0] iwDataWdata,
  input  logic [3:0]  iwDataWstrb,
  output logic        owDataDone,
  output logic [31:0] owDataRdata,
  output logic        owMemEn,
  output logic [31:0] owMemAddr,
  output logic [31:0] owMemWdata,
  output logic [3:0]  owMemWstrb,
  input  logic [31:0] iwMemRdata,
  output logic        owBusy
);

  logic [1:0]        stateReg;
  logic [WAIT_W-1:0] waitCntReg;
  logic              grantIdReg;
  logic              grantValid;
  logic              pickId;
  arbReq_t           pickReq;

  assign grantValid = (stateReg == ARB_STATE_IDLE) && (iwFetchReq || iwDataReq);

  arb_pick_rv #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) uPick (
    .iwClk       (iwClk),
    .iwRst       (iwRst),
    .iwFetchReq  (iwFetchReq),
    .iwDataReq   (iwDataReq),
    .iwGrantValid(grantValid),
    .owGrantId   (pickId)
  );

  // Fetch never writes, so its strobes and write data are forced to zero.
  always_comb begin
    pickReq.grantId = pickId;
    if (pickId == ARB_GRANT_DATA) begin
      pickReq.addr  = wordAlign(iwDataAddr);
      pickReq.wdata = iwDataWdata;
      pickReq.wstrb = iwDataWstrb;
    end else begin
      pickReq.addr  = wordAlign(iwFetchAddr);
      pickReq.wdata = '0;
      pickReq.wstrb = '0;
    end
  end

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      stateReg    <= ARB_STATE_IDLE;
      waitCntReg  <= '0;
      grantIdReg  <= ARB_GRANT_FETCH;
      owMemEn     <= 1'b0;
      owMemAddr   <= '0;
      owMemWdata  <= '0;
      owMemWstrb  <= '0;
      owFetchDone <= 1'b0;
      owFetchData <= '0;
      owDataDone  <= 1'b0;
      owDataRdata <= '0;
      owBusy      <= 1'b0;
    end else begin
      owFetchDone <= 1'b0;
      owDataDone  <= 1'b0;
      case (stateReg)
        ARB_STATE_IDLE: begin
          // The memory-side registers double as the latched grant request.
          if (grantValid) begin
            grantIdReg <= pickReq.grantId;
            owMemEn    <= 1'b1;
            owMemAddr  <= pickReq.addr;
            owMemWdata <= pickReq.wdata;
            owMemWstrb <= pickReq.wstrb;
            owBusy     <= 1'b1;
            stateReg   <= ARB_STATE_ISSUE;
          end
        end
        ARB_STATE_ISSUE: begin
          owMemEn    <= 1'b0;
          waitCntReg <= WAIT_W'(MEM_LATENCY);
          stateReg   <= ARB_STATE_WAIT;
        end
        ARB_STATE_WAIT: begin
          waitCntReg <= waitCntReg - 1'b1;
          if (waitCntReg == WAIT_W'(1)) begin
            stateReg <= ARB_STATE_RESP;
            if (grantIdReg == ARB_GRANT_FETCH) begin
              owFetchData <= iwMemRdata;
              owFetchDone <= 1'b1;
            end else begin
              if (owMemWstrb == 4'b0000) begin
                owDataRdata <= iwMemRdata;
              end
              owDataDone <= 1'b1;
            end
          end
        end
        default: begin
          owBusy   <= 1'b0;
          stateReg <= ARB_STATE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter_rv.sv
// Scoreboard bench: two arbiter instances (latency 1 and 4) share one clock
// and reset, each backed by a small pipelined RAM model.
module tb_mem_port_arbiter_rv;

  typedef struct {
    int          inst;
    bit          isFetch;
    logic [31:0] data;
  } expItem_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchReq[2];
  logic [31:0] fetchAddr[2];
  logic        fetchDone[2];
  logic [31:0] fetchData[2];
  logic        dataReq[2];
  logic [31:0] dataAddr[2];
  logic [31:0] dataWdata[2];
  logic [3:0]  dataWstrb[2];
  logic        dataDone[2];
  logic [31:0] dataRdata[2];
  logic        memEn[2];
  logic [31:0] memAddr[2];
  logic [31:0] memWdata[2];
  logic [3:0]  memWstrb[2];
  logic [31:0] memRdata[2];
  logic        busy[2];

  logic [31:0] mem[2][256];
  logic [31:0] shadow[2][256];
  logic [31:0] pipeData[2][4];
  logic        pipeValid[2][4];
  logic [31:0] lastRdata[2];
  bit          memLoaded = 1'b0;

  expItem_t sbq[$];
  int nChecks = 0;
  int nFails = 0;
  int doneCount = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_rv #(.MEM_LATENCY(1), .MAX_DATA_STREAK(3)) dut1 (
    .iwClk(clk), .iwRst(rst),
    .iwFetchReq(fetchReq[0]), .iwFetchAddr(fetchAddr[0]),
    .owFetchDone(fetchDone[0]), .owFetchData(fetchData[0]),
    .iwDataReq(dataReq[0]), .iwDataAddr(dataAddr[0]),
    .iwDataWdata(dataWdata[0]), .iwDataWstrb(dataWstrb[0]),
    .owDataDone(dataDone[0]), .owDataRdata(dataRdata[0]),
    .owMemEn(memEn[0]), .owMemAddr(memAddr[0]), .owMemWdata(memWdata[0]),
    .owMemWstrb(memWstrb[0]), .iwMemRdata(memRdata[0]), .owBusy(busy[0])
  );

  mem_port_arbiter_rv #(.MEM_LATENCY(4), .MAX_DATA_STREAK(3)) dut4 (
    .iwClk(clk), .iwRst(rst),
    .iwFetchReq(fetchReq[1]), .iwFetchAddr(fetchAddr[1]),
    .owFetchDone(fetchDone[1]), .owFetchData(fetchData[1]),
    .iwDataReq(dataReq[1]), .iwDataAddr(dataAddr[1]),
    .iwDataWdata(dataWdata[1]), .iwDataWstrb(dataWstrb[1]),
    .owDataDone(dataDone[1]), .owDataRdata(dataRdata[1]),
    .owMemEn(memEn[1]), .owMemAddr(memAddr[1]), .owMemWdata(memWdata[1]),
    .owMemWstrb(memWstrb[1]), .iwMemRdata(memRdata[1]), .owBusy(busy[1])
  );

  function automatic logic [31:0] initWord(input int k, input int i);
    if (k == 0 && i == 65) return 32'h0000_0013;
    return 32'hA500_0000 | (32'(k) << 16) | 32'(i);
  endfunction

  // RAM model: data appears MEM_LATENCY cycles after the enable cycle, garbage otherwise.
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 256; i++) mem[k][i] = initWord(k, i);
      memLoaded = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      for (int s = 3; s > 0; s--) begin
        pipeData[k][s]  <= pipeData[k][s-1];
        pipeValid[k][s] <= rst ? 1'b0 : pipeValid[k][s-1];
      end
      pipeValid[k][0] <= rst ? 1'b0 : memEn[k];
      pipeData[k][0]  <= mem[k][memAddr[k][9:2]];
      if (memEn[k] === 1'b1) begin
        for (int b = 0; b < 4; b++)
          if (memWstrb[k][b]) mem[k][memAddr[k][9:2]][8*b +: 8] = memWdata[k][8*b +: 8];
      end
    end
  end

  assign memRdata[0] = pipeValid[0][0] ? pipeData[0][0] : 32'hBAD0_BAD0;
  assign memRdata[1] = pipeValid[1][3] ? pipeData[1][3] : 32'hBAD0_BAD0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pushExp(input int k, input bit isFetch, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    expItem_t it;
    int w;
    w = int'(addr[9:2]);
    it.inst = k;
    it.isFetch = isFetch;
    if (isFetch || wstrb == 4'b0000) begin
      it.data = shadow[k][w];
      if (!isFetch) lastRdata[k] = it.data;
    end else begin
      it.data = lastRdata[k];
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) shadow[k][w][8*b +: 8] = wdata[8*b +: 8];
    end
    sbq.push_back(it);
  endtask

  task automatic driveReq(input int k, input bit isFetch, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    if (isFetch) begin
      fetchReq[k] = 1'b1;
      fetchAddr[k] = addr;
    end else begin
      dataReq[k] = 1'b1;
      dataAddr[k] = addr;
      dataWdata[k] = wdata;
      dataWstrb[k] = wstrb;
    end
  endtask

  // Cycle-exact checks from cycle firstC through the done cycle, then release.
  task automatic checkCycles(input int k, input bit isFetch, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb, input int firstC);
    int lat;
    lat = (k == 0) ? 1 : 4;
    for (int c = firstC; c <= 2 + lat; c++) begin
      @(negedge clk);
      checkEq($sformatf("i%0d_c%0d_memEn", k, c), 32'(memEn[k]), 32'(c == 1));
      checkEq($sformatf("i%0d_c%0d_busy", k, c), 32'(busy[k]), 32'(c >= 1));
      checkEq($sformatf("i%0d_c%0d_done", k, c),
              32'(isFetch ? fetchDone[k] : dataDone[k]), 32'(c == 2 + lat));
      if (c == 1) begin
        checkEq($sformatf("i%0d_memAddr", k), memAddr[k], addr & 32'hFFFF_FFFC);
        checkEq($sformatf("i%0d_memWstrb", k), 32'(memWstrb[k]), 32'(wstrb));
        if (!isFetch) checkEq($sformatf("i%0d_memWdata", k), memWdata[k], wdata);
      end
    end
    @(posedge clk);
    #1;
    fetchReq[k] = 1'b0;
    dataReq[k] = 1'b0;
  endtask

  task automatic runTimed(input int k, input bit isFetch, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    pushExp(k, isFetch, addr, wdata, wstrb);
    driveReq(k, isFetch, addr, wdata, wstrb);
    checkCycles(k, isFetch, addr, wdata, wstrb, 0);
  endtask

  task automatic resetChk(input int k);
    checkEq($sformatf("rst%0d_memEn", k), 32'(memEn[k]), 0);
    checkEq($sformatf("rst%0d_memAddr", k), memAddr[k], 0);
    checkEq($sformatf("rst%0d_memWdata", k), memWdata[k], 0);
    checkEq($sformatf("rst%0d_memWstrb", k), 32'(memWstrb[k]), 0);
    checkEq($sformatf("rst%0d_fetchDone", k), 32'(fetchDone[k]), 0);
    checkEq($sformatf("rst%0d_dataDone", k), 32'(dataDone[k]), 0);
    checkEq($sformatf("rst%0d_fetchData", k), fetchData[k], 0);
    checkEq($sformatf("rst%0d_dataRdata", k), dataRdata[k], 0);
    checkEq($sformatf("rst%0d_busy", k), 32'(busy[k]), 0);
  endtask

  // Scoreboard side: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (fetchDone[k] === 1'b1 || dataDone[k] === 1'b1) begin
        doneCount++;
        if (sbq.size() == 0) begin
          checkEq($sformatf("i%0d_unexpected_done", k), 32'(sbq.size()), 1);
        end else begin
          expItem_t it;
          logic [31:0] got;
          it = sbq.pop_front();
          got = (fetchDone[k] === 1'b1) ? fetchData[k] : dataRdata[k];
          checkEq("sb_inst", 32'(k), 32'(it.inst));
          checkEq("sb_kind", 32'(fetchDone[k]), 32'(it.isFetch));
          checkEq("sb_data", got, it.data);
          $display("txn inst=%0d kind=%s data=%08h expected=%08h", k,
                   (fetchDone[k] === 1'b1) ? "fetch" : "data", got, it.data);
        end
      end
    end
  end

  initial begin
    int base;
    int timer;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      fetchReq[k] = 1'b0; fetchAddr[k] = '0;
      dataReq[k] = 1'b0; dataAddr[k] = '0; dataWdata[k] = '0; dataWstrb[k] = '0;
      lastRdata[k] = '0;
      for (int i = 0; i < 256; i++) shadow[k][i] = initWord(k, i);
    end
    @(posedge clk);
    #1;
    resetChk(0);
    resetChk(1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    runTimed(0, 1'b1, 32'h0000_0106, 32'h0, 4'b0000);
    runTimed(0, 1'b0, 32'h0000_0044, 32'h0, 4'b0000);
    runTimed(0, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0011);
    runTimed(0, 1'b0, 32'h0000_0020, 32'h0, 4'b0000);

    // Both requesters held: expect D,D,D,F,D,D,D,F.
    base = doneCount;
    for (int g = 0; g < 8; g++)
      pushExp(0, (g % 4) == 3, ((g % 4) == 3) ? 32'h80 : 32'h44, 32'h0, 4'b0000);
    driveReq(0, 1'b1, 32'h80, 32'h0, 4'b0000);
    driveReq(0, 1'b0, 32'h44, 32'h0, 4'b0000);
    timer = 0;
    while (doneCount < base + 8 && timer < 200) begin
      @(posedge clk);
      timer++;
    end
    checkEq("grant_seq_count", 32'(doneCount - base), 8);
    #1;
    fetchReq[0] = 1'b0;
    dataReq[0] = 1'b0;

    runTimed(1, 1'b0, 32'h0000_0030, 32'h0, 4'b0000);

    // Asynchronous reset in the middle of WAIT abandons the access.
    driveReq(1, 1'b0, 32'h0000_0034, 32'h0, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    resetChk(0);
    resetChk(1);
    repeat (2) @(posedge clk);
    lastRdata[0] = '0;
    lastRdata[1] = '0;
    pushExp(1, 1'b0, 32'h0000_0034, 32'h0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    checkCycles(1, 1'b0, 32'h0000_0034, 32'h0, 4'b0000, 1);

    repeat (3) @(posedge clk);
    checkEq("sb_leftover", 32'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
